// File: rtl/run_ctrl_if.sv
// run_ctrl_if: groups the run controller's control inputs and status outputs.
// The slave modport is the controller's view. The master modport is the
// view of whatever drives the controller.
interface run_ctrl_if #(
  parameter int CHANNELS = 8,
  parameter int TO_W     = 32,
  parameter int STALL_W  = 16
);
  localparam int HW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                start;
  logic [TO_W-1:0]     timeout_cfg;
  logic [STALL_W-1:0]  stall_limit;
  logic [CHANNELS-1:0] halt;
  logic [CHANNELS-1:0] commit;
  logic                mon_err;
  logic                mem_err;

  logic                dut_rst;
  logic [2:0]          state;
  logic                done;
  logic                pass;
  logic [2:0]          fail_code;
  logic [HW-1:0]       halt_ch;
  logic [TO_W-1:0]     run_cycles;

  modport slave (
    input  start, timeout_cfg, stall_limit, halt, commit, mon_err, mem_err,
    output dut_rst, state, done, pass, fail_code, halt_ch, run_cycles
  );

  modport master (
    output start, timeout_cfg, stall_limit, halt, commit, mon_err, mem_err,
    input  dut_rst, state, done, pass, fail_code, halt_ch, run_cycles
  );
endinterface

// File: rtl/run_ctrl.sv
// run_ctrl: sequences one test run of a DUT.
// The sequence is: hold the DUT in reset, run it until a channel halts,
// an error is flagged, the cycle budget runs out or progress stalls,
// then report a terminal PASS or FAIL verdict.
module run_ctrl #(
  parameter int CHANNELS     = 8,
  parameter int TO_W         = 32,
  parameter int RST_CYCLES   = 2,
  parameter int DRAIN_CYCLES = 5,
  parameter int STALL_W      = 16
) (
  input  logic      clk,
  input  logic      rst,
  run_ctrl_if.slave bus
);
  localparam int HW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PH_MAX = (RST_CYCLES > DRAIN_CYCLES) ? RST_CYCLES : DRAIN_CYCLES;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RESET = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_PASS  = 3'd4,
    ST_FAIL  = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    FC_NONE    = 3'd0,
    FC_TIMEOUT = 3'd1,
    FC_MON_ERR = 3'd2,
    FC_MEM_ERR = 3'd3,
    FC_STALL   = 3'd4
  } fail_t;

  state_t             state_q, state_d;
  fail_t              code_q, code_d;
  logic [TO_W-1:0]    to_cnt, to_d;
  logic [TO_W-1:0]    run_cyc, cyc_d;
  logic [STALL_W-1:0] stall_lim, lim_d;
  logic [STALL_W-1:0] stall_cnt, stall_d;
  logic [PH_W-1:0]    ph_cnt, ph_d;
  logic [HW-1:0]      halt_ch_q, hch_d;
  logic [HW-1:0]      first_halt;

  // Find the lowest-index channel that is currently asserting halt
  always_comb begin
    first_halt = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (bus.halt[i]) first_halt = HW'(i);
    end
  end

  // Compute the next state and datapath values; RUN checks its exits in fixed priority
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    to_d    = to_cnt;
    cyc_d   = run_cyc;
    lim_d   = stall_lim;
    stall_d = stall_cnt;
    ph_d    = ph_cnt;
    hch_d   = halt_ch_q;

    if ((state_q == ST_RUN || state_q == ST_DRAIN) && run_cyc != '1)
      cyc_d = run_cyc + TO_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_RESET;
          to_d    = bus.timeout_cfg;
          lim_d   = bus.stall_limit;
          cyc_d   = '0;
          stall_d = '0;
          ph_d    = '0;
        end
      end
      ST_RESET: begin
        stall_d = '0;
        if (ph_cnt == PH_W'(RST_CYCLES - 1)) begin
          ph_d    = '0;
          state_d = ST_RUN;
        end else begin
          ph_d = ph_cnt + PH_W'(1);
        end
      end
      ST_RUN: begin
        if (bus.commit != '0)
          stall_d = '0;
        else if (stall_cnt != '1)
          stall_d = stall_cnt + STALL_W'(1);

        if (bus.halt != '0) begin
          state_d = ST_PASS;
          hch_d   = first_halt;
        end else if (bus.mon_err) begin
          state_d = ST_DRAIN;
          code_d  = FC_MON_ERR;
          ph_d    = '0;
        end else if (bus.mem_err) begin
          state_d = ST_DRAIN;
          code_d  = FC_MEM_ERR;
          ph_d    = '0;
        end else if (to_cnt == '0) begin
          state_d = ST_FAIL;
          code_d  = FC_TIMEOUT;
        end else if (stall_lim != '0 && stall_cnt == stall_lim) begin
          state_d = ST_FAIL;
          code_d  = FC_STALL;
        end else begin
          to_d = to_cnt - TO_W'(1);
        end
      end
      ST_DRAIN: begin
        if (ph_cnt == PH_W'(DRAIN_CYCLES - 1)) begin
          ph_d    = '0;
          state_d = ST_FAIL;
        end else begin
          ph_d = ph_cnt + PH_W'(1);
        end
      end
      ST_PASS, ST_FAIL: begin
        state_d = state_q;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Register state and datapath; a low rst aborts any run back to IDLE
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      code_q    <= FC_NONE;
      to_cnt    <= '0;
      run_cyc   <= '0;
      stall_lim <= '0;
      stall_cnt <= '0;
      ph_cnt    <= '0;
      halt_ch_q <= '0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      to_cnt    <= to_d;
      run_cyc   <= cyc_d;
      stall_lim <= lim_d;
      stall_cnt <= stall_d;
      ph_cnt    <= ph_d;
      halt_ch_q <= hch_d;
    end
  end

  assign bus.dut_rst    = (state_q == ST_IDLE) || (state_q == ST_RESET);
  assign bus.state      = state_q;
  assign bus.done       = (state_q == ST_PASS) || (state_q == ST_FAIL);
  assign bus.pass       = (state_q == ST_PASS);
  assign bus.fail_code  = code_q;
  assign bus.halt_ch    = halt_ch_q;
  assign bus.run_cycles = run_cyc;
endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: randomized and directed runs of run_ctrl.
// Each run's outcome is predicted by scanning its per-cycle stimulus
// table with the controller's rules.
module tb_run_ctrl;
  localparam int CH        = 8;
  localparam int TO_W      = 32;
  localparam int RST_CYC   = 2;
  localparam int DRAIN_CYC = 5;
  localparam int STALL_W   = 16;
  localparam int MAXK      = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;

  run_ctrl_if #(.CHANNELS(CH), .TO_W(TO_W), .STALL_W(STALL_W)) bus ();

  run_ctrl #(
    .CHANNELS(CH), .TO_W(TO_W), .RST_CYCLES(RST_CYC),
    .DRAIN_CYCLES(DRAIN_CYC), .STALL_W(STALL_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Free-running clock
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [CH-1:0] s_halt   [MAXK];
  logic [CH-1:0] s_commit [MAXK];
  logic          s_mon    [MAXK];
  logic          s_mem    [MAXK];

  int exp_state, exp_code, exp_hch, exp_k, exp_cyc;
  bit exp_drain;

  task automatic checkOutput(input string tag, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic zeroInputs();
    bus.start       = 1'b0;
    bus.timeout_cfg = '0;
    bus.stall_limit = '0;
    bus.halt        = '0;
    bus.commit      = '0;
    bus.mon_err     = 1'b0;
    bus.mem_err     = 1'b0;
  endtask

  task automatic clearStim(input bit with_commit);
    for (int k = 0; k < MAXK; k++) begin
      s_halt[k]   = '0;
      s_commit[k] = with_commit ? CH'(1) : '0;
      s_mon[k]    = 1'b0;
      s_mem[k]    = 1'b0;
    end
  endtask

  task automatic fillRandom();
    for (int k = 0; k < MAXK; k++) begin
      s_halt[k]   = ($urandom_range(0, 29) == 0) ? CH'($urandom) : '0;
      s_commit[k] = ($urandom_range(0, 2) == 0) ? '0 : CH'($urandom | 1);
      s_mon[k]    = ($urandom_range(0, 39) == 0);
      s_mem[k]    = ($urandom_range(0, 39) == 0);
    end
  endtask

  // Walk RUN cycles 1,2,... applying the exit rules in priority order
  task automatic computeExpected(input int n_cfg, input int l_cfg);
    int  free;
    bit  ended;
    bit  found;
    free      = 0;
    ended     = 1'b0;
    exp_state = 5;
    exp_code  = 1;
    exp_hch   = 0;
    exp_k     = MAXK - 1;
    exp_drain = 1'b0;
    for (int k = 1; k < MAXK && !ended; k++) begin
      if (s_halt[k] != '0) begin
        ended     = 1'b1;
        exp_state = 4;
        exp_code  = 0;
        found     = 1'b0;
        for (int i = 0; i < CH; i++) begin
          if (!found && s_halt[k][i]) begin
            exp_hch = i;
            found   = 1'b1;
          end
        end
      end else if (s_mon[k]) begin
        ended = 1'b1; exp_code = 2; exp_drain = 1'b1;
      end else if (s_mem[k]) begin
        ended = 1'b1; exp_code = 3; exp_drain = 1'b1;
      end else if (k == n_cfg + 1) begin
        ended = 1'b1; exp_code = 1;
      end else if (l_cfg != 0 && free == l_cfg) begin
        ended = 1'b1; exp_code = 4;
      end
      if (ended) exp_k = k;
      else free = (s_commit[k] != '0) ? 0 : free + 1;
    end
    exp_cyc = exp_k + (exp_drain ? DRAIN_CYC : 0);
  endtask

  task automatic driveCycle(input int k);
    int kk;
    if (k < 1) begin
      bus.halt = '0; bus.commit = '0; bus.mon_err = 1'b0; bus.mem_err = 1'b0;
    end else begin
      kk = (k > MAXK - 1) ? MAXK - 1 : k;
      bus.halt    = s_halt[kk];
      bus.commit  = s_commit[kk];
      bus.mon_err = s_mon[kk];
      bus.mem_err = s_mem[kk];
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "/state"},     longint'(bus.state), 0);
    checkOutput({tag, "/dut_rst"},   longint'(bus.dut_rst), 1);
    checkOutput({tag, "/done"},      longint'(bus.done), 0);
    checkOutput({tag, "/pass"},      longint'(bus.pass), 0);
    checkOutput({tag, "/fail_code"}, longint'(bus.fail_code), 0);
    checkOutput({tag, "/halt_ch"},   longint'(bus.halt_ch), 0);
    checkOutput({tag, "/run_cyc"},   longint'(bus.run_cycles), 0);
  endtask

  // Reset, start one run from the stimulus table and check the verdict
  task automatic applyStimulus(input string tag, input int n_cfg, input int l_cfg);
    int first_low, done_at, exp_done;
    longint cyc_at_done;
    computeExpected(n_cfg, l_cfg);
    @(negedge clk);
    rst = 1'b0;
    zeroInputs();
    @(negedge clk);
    rst = 1'b1;
    bus.start       = 1'b1;
    bus.timeout_cfg = TO_W'(n_cfg);
    bus.stall_limit = STALL_W'(l_cfg);
    first_low = -1;
    done_at   = -1;
    for (int j = 1; j <= MAXK + RST_CYC + DRAIN_CYC + 10 && done_at < 0; j++) begin
      @(negedge clk);
      bus.start       = 1'b0;
      bus.timeout_cfg = TO_W'($urandom);
      bus.stall_limit = STALL_W'($urandom);
      if (first_low < 0 && bus.dut_rst == 1'b0) first_low = j;
      if (bus.done) done_at = j;
      else driveCycle(j - RST_CYC);
    end
    exp_done = RST_CYC + exp_k + 1 + (exp_drain ? DRAIN_CYC : 0);
    checkOutput({tag, "/rst_len"},   first_low - 1, RST_CYC);
    checkOutput({tag, "/done_at"},   done_at, exp_done);
    checkOutput({tag, "/state"},     longint'(bus.state), exp_state);
    checkOutput({tag, "/pass"},      longint'(bus.pass), (exp_state == 4) ? 1 : 0);
    checkOutput({tag, "/fail_code"}, longint'(bus.fail_code), exp_code);
    checkOutput({tag, "/halt_ch"},   longint'(bus.halt_ch), exp_hch);
    checkOutput({tag, "/run_cyc"},   longint'(bus.run_cycles), exp_cyc);
    checkOutput({tag, "/dut_rst"},   longint'(bus.dut_rst), 0);
    cyc_at_done = longint'(bus.run_cycles);
    bus.start = 1'b1;
    driveCycle(1);
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput({tag, "/terminal"},  longint'(bus.state), exp_state);
    checkOutput({tag, "/cyc_hold"},  longint'(bus.run_cycles), cyc_at_done);
  endtask

  // Start a run and pull rst low at the given negedge, then check it aborted
  task automatic abortRun(input string tag, input int abort_j, input int pre_state);
    @(negedge clk);
    rst = 1'b0;
    zeroInputs();
    @(negedge clk);
    rst = 1'b1;
    bus.start       = 1'b1;
    bus.timeout_cfg = TO_W'(50);
    for (int j = 1; j <= abort_j; j++) begin
      @(negedge clk);
      bus.start = 1'b0;
      driveCycle(j - RST_CYC);
    end
    checkOutput({tag, "/pre_state"}, longint'(bus.state), pre_state);
    rst = 1'b0;
    zeroInputs();
    @(negedge clk);
    checkResetValues({tag, "/abort"});
    rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    zeroInputs();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkResetValues("reset");

    bus.start = 1'b1;
    bus.timeout_cfg = TO_W'(7);
    @(negedge clk);
    checkOutput("start_in_rst/state", longint'(bus.state), 0);
    rst = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    checkOutput("start_in_rst/idle", longint'(bus.state), 0);

    clearStim(1'b1); s_halt[20] = CH'(8'h20);
    applyStimulus("pass_halt5", 100, 0);
    clearStim(1'b1);
    applyStimulus("timeout10", 10, 0);
    clearStim(1'b1); s_mem[4] = 1'b1; s_halt[6] = CH'(8'h01);
    applyStimulus("mem_drain", 100, 0);
    clearStim(1'b1); s_halt[3] = CH'(8'h84); s_mon[3] = 1'b1;
    applyStimulus("halt_prio", 100, 0);
    clearStim(1'b0);
    for (int k = 1; k <= 4; k++) s_commit[k] = CH'(8'h03);
    applyStimulus("stall3", 1000, 3);
    clearStim(1'b1);
    applyStimulus("timeout0", 0, 0);
    clearStim(1'b1); s_mon[5] = 1'b1; s_mem[5] = 1'b1;
    applyStimulus("mon_mem", 100, 0);
    clearStim(1'b0);
    applyStimulus("stall_off", 12, 0);

    clearStim(1'b1); s_mem[3] = 1'b1;
    abortRun("abort_drain", RST_CYC + 5, 3);
    clearStim(1'b1);
    abortRun("abort_reset", 1, 1);
    clearStim(1'b1); s_halt[20] = CH'(8'h20);
    applyStimulus("after_abort", 100, 0);

    for (int r = 0; r < 25; r++) begin
      fillRandom();
      applyStimulus($sformatf("rand%0d", r), int'($urandom_range(0, 40)),
                    ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 5)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 SHALL have parameter CHANNELS, default 8, number of halt/commit channels (1..32).
REQ-002 SHALL have parameter TO_W, default 32, width of the timeout counter and cycle counter.
REQ-003 SHALL have parameter RST_CYCLES, default 2, cycles dut_rst is held after start.
REQ-004 SHALL have parameter DRAIN_CYCLES, default 5, cycles between error detection and fail.
REQ-005 SHALL have parameter STALL_W, default 16, width of stall watchdog limit.
REQ-006 clk  in  1  single clock; all state changes on rising edge.
REQ-007 rst  in  1  synchronous, active-low reset (rst==0 resets on a clk edge).
REQ-008 start  in  1  one-cycle pulse; begins a run from IDLE, ignored elsewhere.
REQ-009 timeout_cfg  in  TO_W  run cycle budget, sampled on the start cycle.
REQ-010 stall_limit  in  STALL_W  max RUN cycles with no commit; 0 disables, sampled on start.
REQ-011 halt  in  CHANNELS  per-channel halt indication.
REQ-012 commit  in  CHANNELS  per-channel retire/progress indication.
REQ-013 mon_err  in  1  monitor error flag.
REQ-014 mem_err  in  1  memory model error flag.
REQ-015 dut_rst  out  1  active-high reset driven to the DUT.
REQ-016 state  out  3  IDLE=0, RESET=1, RUN=2, DRAIN=3, PASS=4, FAIL=5.
REQ-017 done  out  1  high in PASS or FAIL.
REQ-018 pass  out  1  high in PASS only.
REQ-019 fail_code  out  3  NONE=0, TIMEOUT=1, MON_ERR=2, MEM_ERR=3, STALL=4.
REQ-020 halt_ch  out  $clog2(CHANNELS)  lowest-index channel asserting halt when PASS is entered.
REQ-021 run_cycles  out  TO_W  RUN+DRAIN cycles elapsed, saturating at all-ones.

Function
REQ-022 IDLE: dut_rst=1; start -> RESET, latch timeout_cfg into to_cnt and stall_limit, clear run_cycles.
REQ-023 RESET: dut_rst=1 for exactly RST_CYCLES cycles, then -> RUN; dut_rst=0 on the first RUN cycle.
REQ-024 RUN, evaluated each cycle with fixed priority: any halt bit -> PASS; else mon_err -> DRAIN with code MON_ERR; else mem_err -> DRAIN with code MEM_ERR; else to_cnt==0 -> FAIL TIMEOUT; else stall counter==stall_limit (limit!=0) -> FAIL STALL; else to_cnt decrements by 1.
REQ-025 mon_err and mem_err in the same cycle SHALL record MON_ERR.
REQ-026 Stall counter SHALL clear on any cycle with commit!=0, otherwise increment saturating; starts at 0 on RUN entry.
REQ-027 timeout_cfg=N SHALL permit exactly N RUN cycles; FAIL TIMEOUT entered on the edge ending RUN cycle N+1 (N=0 fails after first RUN cycle).
REQ-028 DRAIN: held DRAIN_CYCLES cycles, halt/errors/timeout ignored, fail_code frozen, then -> FAIL.
REQ-029 PASS and FAIL SHALL be terminal until rst; start ignored; dut_rst=0 in PASS/FAIL/RUN/DRAIN.
REQ-030 halt_ch SHALL be captured only on RUN->PASS; fail_code only on the detecting transition.
REQ-031 run_cycles SHALL increment in RUN and DRAIN, hold otherwise.

Reset
REQ-032 On rst==0: state=IDLE, dut_rst=1, done=0, pass=0, fail_code=NONE, halt_ch=0, run_cycles=0, counters=0.
REQ-033 rst==0 in any state, including mid-RESET or mid-DRAIN, SHALL abort the run with REQ-032 values on the next edge.
REQ-034 start coincident with rst==0 SHALL be ignored.

Verification
REQ-035 start, timeout_cfg=100, commit every cycle, halt[5] at RUN cycle 20 -> PASS, pass=1, halt_ch=5, fail_code=0, run_cycles=20.
REQ-036 timeout_cfg=10, no halt, commit each cycle -> FAIL, fail_code=1, run_cycles=11, dut_rst high exactly 2 cycles after start.
REQ-037 mem_err pulse at RUN cycle 4, halt at cycle 6 -> DRAIN 5 cycles, FAIL, fail_code=3, pass=0.
REQ-038 halt[2], halt[7], mon_err same cycle -> PASS, halt_ch=2.
REQ-039 stall_limit=3, commit stops at RUN cycle 5, timeout_cfg=1000 -> FAIL, fail_code=4 after 3 commit-free cycles.
REQ-040 rst==0 during DRAIN cycle 2 -> IDLE, dut_rst=1, fail_code=0; subsequent start runs normally.
